// File: rtl/wb_stage.sv
// Writeback stage: accepts one completed instruction, performs an optional
// aligned load, and issues exactly one registered register-file write.
module wb_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  retire,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] busy_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rd_we_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;

    logic                  accept;
    logic                  in_bad;
    logic                  go_write;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;

    assign in_ready      = !rst_n || (state == IDLE) || (state == WRITE);
    assign accept        = in_valid && in_ready;
    // Non-loads and faulting loads skip the memory and write next cycle.
    assign go_write      = accept && (!in_is_load || in_bad);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign busy          = (state != IDLE);
    assign busy_rd       = (busy && rd_we_q) ? rd_q : '0;

    // Classify the incoming load as misaligned or illegal.
    always_comb begin
        in_bad = 1'b0;
        unique case (in_funct3)
            3'b000, 3'b100: in_bad = 1'b0;
            3'b001, 3'b101: in_bad = in_result[0];
            3'b010:         in_bad = |in_result[1:0];
            default:        in_bad = 1'b1;
        endcase
    end

    // Extract and extend the addressed byte/halfword of the response word.
    always_comb begin
        byte_sel = mem_rsp_data[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        load_val = mem_rsp_data;
        unique case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'b0, half_sel};
            default: load_val = mem_rsp_data;
        endcase
    end

    // Next-state logic; an accept in WRITE chains straight into the next op.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, WRITE: begin
                if (accept) state_d = go_write ? WRITE : REQ;
                else        state_d = IDLE;
            end
            REQ:     if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_rsp_valid) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Latch the fields of the accepted instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rd_we_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
        end else if (accept) begin
            rd_q     <= in_rd;
            rd_we_q  <= in_rd_we;
            funct3_q <= in_funct3;
            addr_q   <= in_result;
        end
    end

    // Registered write-port outputs, loaded on entry to WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retire   <= 1'b0;
            err      <= 1'b0;
        end else begin
            rf_wen <= 1'b0;
            retire <= 1'b0;
            err    <= 1'b0;
            if (go_write) begin
                rf_waddr <= in_rd;
                retire   <= 1'b1;
                err      <= in_is_load;
                rf_wen   <= in_rd_we && (in_rd != '0) && !in_is_load;
                if (!in_is_load) rf_wdata <= in_result;
            end else if (state == WAIT && mem_rsp_valid) begin
                rf_waddr <= rd_q;
                rf_wdata <= load_val;
                retire   <= 1'b1;
                rf_wen   <= rd_we_q && (rd_q != '0);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table of single instructions plus
// hand-written multi-cycle sequences (pipelined ALU, delayed load, reset).
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;
    logic        err;
    logic        busy;
    logic [4:0]  busy_rd;

    wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_result(in_result),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .err(err), .busy(busy), .busy_rd(busy_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic [2:0]  f3;
        logic [31:0] result;
        logic [31:0] rsp;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] rsp, input logic ewen,
                       input logic [31:0] ewd, input logic eerr);
        vec_t v;
        v.rd = rd; v.rd_we = we; v.is_load = ld; v.f3 = f3;
        v.result = res; v.rsp = rsp; v.exp_wen = ewen;
        v.exp_wdata = ewd; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [31:0] res);
        in_valid = 1'b1; in_rd = rd; in_rd_we = we;
        in_is_load = ld; in_funct3 = f3; in_result = res;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_rd_we = 1'b0;
        in_is_load = 1'b0; in_funct3 = 3'b000; in_result = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        add(5'd5, 1, 0, 3'b000, 32'h1234_5678, 0, 1, 32'h1234_5678, 0);
        add(5'd0, 1, 0, 3'b000, 32'h0000_DEAD, 0, 0, 32'h0000_DEAD, 0);
        add(5'd7, 0, 0, 3'b000, 32'h0000_0077, 0, 0, 32'h0000_0077, 0);
        add(5'd8, 1, 1, 3'b101, 32'h0000_1002, 32'hBEEF_1234, 1, 32'h0000_BEEF, 0);
        add(5'd9, 1, 1, 3'b001, 32'h0000_1002, 32'hBEEF_1234, 1, 32'hFFFF_BEEF, 0);
        add(5'd10, 1, 1, 3'b010, 32'h0000_1000, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, 0);
        add(5'd11, 1, 1, 3'b100, 32'h0000_1001, 32'h1122_8344, 1, 32'h0000_0083, 0);
        add(5'd12, 1, 1, 3'b000, 32'h0000_1001, 32'h1122_8344, 1, 32'hFFFF_FF83, 0);
        add(5'd13, 1, 1, 3'b000, 32'h0000_1000, 32'h0000_007F, 1, 32'h0000_007F, 0);
        add(5'd14, 1, 1, 3'b001, 32'h0000_1000, 32'h0000_8001, 1, 32'hFFFF_8001, 0);
        add(5'd15, 1, 1, 3'b010, 32'h0000_1002, 0, 0, 0, 1);
        add(5'd16, 1, 1, 3'b011, 32'h0000_1000, 0, 0, 0, 1);
        add(5'd17, 1, 1, 3'b001, 32'h0000_1001, 0, 0, 0, 1);
        add(5'd18, 1, 1, 3'b110, 32'h0000_1000, 0, 0, 0, 1);
        add(5'd0, 1, 1, 3'b010, 32'h0000_1004, 32'h5555_AAAA, 0, 32'h5555_AAAA, 0);

        // Reset state
        #1;
        chk("ready_in_reset", in_ready, 1);
        tick(); tick();
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy_rd", busy_rd, 0);
        chk("rst_mreq", mem_req_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", in_ready, 1);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rd, v.rd_we, v.is_load, v.f3, v.result);
            chk($sformatf("v%0d_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            if (v.is_load && !v.exp_err) begin
                chk($sformatf("v%0d_mreq", i), mem_req_valid, 1);
                chk($sformatf("v%0d_maddr", i), mem_req_addr,
                    {v.result[31:2], 2'b00});
                chk($sformatf("v%0d_busy_rd", i), busy_rd,
                    v.rd_we ? v.rd : 5'd0);
                chk($sformatf("v%0d_early_ret", i), retire, 0);
                mem_req_ready = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                chk($sformatf("v%0d_wait_mreq", i), mem_req_valid, 0);
                chk($sformatf("v%0d_wait_busy", i), busy, 1);
                mem_rsp_valid = 1'b1;
                mem_rsp_data = v.rsp;
                tick();
                mem_rsp_valid = 1'b0;
            end else begin
                chk($sformatf("v%0d_nomreq", i), mem_req_valid, 0);
            end
            chk($sformatf("v%0d_wen", i), rf_wen, v.exp_wen);
            chk($sformatf("v%0d_retire", i), retire, 1);
            chk($sformatf("v%0d_err", i), err, v.exp_err);
            if (!v.exp_err) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr, v.rd);
                chk($sformatf("v%0d_wdata", i), rf_wdata, v.exp_wdata);
            end
            tick();
            chk($sformatf("v%0d_idle_wen", i), rf_wen, 0);
            chk($sformatf("v%0d_idle_ret", i), retire, 0);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // Back-to-back ALU ops
        drive(5'd1, 1, 0, 3'b000, 32'h11);
        chk("b2b_ready1", in_ready, 1);
        tick();
        chk("b2b_wen1", rf_wen, 1);
        chk("b2b_waddr1", rf_waddr, 1);
        chk("b2b_wdata1", rf_wdata, 32'h11);
        chk("b2b_busy_rd1", busy_rd, 1);
        drive(5'd2, 1, 0, 3'b000, 32'h22);
        chk("b2b_ready2", in_ready, 1);
        tick();
        chk("b2b_wen2", rf_wen, 1);
        chk("b2b_waddr2", rf_waddr, 2);
        chk("b2b_wdata2", rf_wdata, 32'h22);
        drive(5'd3, 1, 0, 3'b000, 32'h33);
        chk("b2b_ready3", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_wen3", rf_wen, 1);
        chk("b2b_waddr3", rf_waddr, 3);
        chk("b2b_wdata3", rf_wdata, 32'h33);
        chk("b2b_ret3", retire, 1);
        tick();
        chk("b2b_end_wen", rf_wen, 0);
        chk("b2b_end_busy", busy, 0);

        // LB with delayed request acceptance and a stray response in REQ
        drive(5'd4, 1, 1, 3'b000, 32'h8000_0003);
        tick();
        in_valid = 1'b0;
        chk("lb_mreq", mem_req_valid, 1);
        chk("lb_maddr", mem_req_addr, 32'h8000_0000);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lb_req_hold", mem_req_valid, 1);
        chk("lb_req_noret", retire, 0);
        chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
        tick();
        chk("lb_req_hold2", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("lb_wait_mreq", mem_req_valid, 0);
        chk("lb_wait_ret", retire, 0);
        tick();
        chk("lb_wait2_ret", retire, 0);
        chk("lb_wait2_busy_rd", busy_rd, 4);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h80FF_0000;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lb_wen", rf_wen, 1);
        chk("lb_waddr", rf_waddr, 4);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lb_ret", retire, 1);
        tick();
        chk("lb_end_wen", rf_wen, 0);

        // Reset while in WAIT, late response afterwards
        drive(5'd9, 1, 1, 3'b010, 32'h0000_2000);
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        chk("rw_in_wait", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("rw_busy", busy, 0);
        chk("rw_ready", in_ready, 1);
        chk("rw_mreq", mem_req_valid, 0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hAAAA_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rw_late_wen", rf_wen, 0);
        chk("rw_late_ret", retire, 0);
        chk("rw_late_busy", busy, 0);

        // Spurious response in IDLE
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("sp_wen", rf_wen, 0);
        chk("sp_ret", retire, 0);
        chk("sp_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
